// File: rtl/ibex_tlul_core_pkg.sv
// Shared types and constants for the ibex_tlul_core fetch front-end.

package ibex_tlul_core_pkg;
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StRsp  = 2'd2,
    StHalt = 2'd3
  } fetch_state_e;

  localparam logic [7:0] BootOffset = 8'h80;
  localparam int unsigned FetchSize = 2;

  function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction
endpackage

// File: rtl/ibex_tlul_deps_pkg.sv
// Minimal slices of the shared SoC packages (mubi, RAM config, TL-UL, Ibex)
// used by the ibex_tlul_core CPU slot.

package prim_mubi_pkg;
  typedef enum logic [3:0] {
    MuBi4True  = 4'h6,
    MuBi4False = 4'h9
  } mubi4_t;
endpackage

package prim_ram_1p_pkg;
  typedef struct packed {
    logic       cfg_en;
    logic [3:0] cfg;
  } ram_1p_cfg_t;
endpackage

package tlul_pkg;
  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic [4:0] rsvd;
    logic [3:0] instr_type;
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  localparam tl_a_user_t TL_A_USER_DEFAULT = '{
    rsvd:       5'h00,
    instr_type: 4'h9,
    cmd_intg:   7'h00,
    data_intg:  7'h00
  };

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    tl_a_user_t  a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [13:0] d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

package ibex_pkg;
  localparam prim_mubi_pkg::mubi4_t FetchEnableOn  = prim_mubi_pkg::MuBi4True;
  localparam prim_mubi_pkg::mubi4_t FetchEnableOff = prim_mubi_pkg::MuBi4False;

  typedef struct packed {
    logic [31:0] current_pc;
    logic [31:0] next_pc;
    logic [31:0] last_data_addr;
    logic [31:0] exception_pc;
    logic [31:0] exception_addr;
  } crash_dump_t;
endpackage

// File: rtl/ibex_tlul_fetch_fsm.sv
// Sequential word fetcher: PC, fetch state and the TL-UL A/D handshake.
// IBEX_TLUL_BUS_ERR_ALERT_EN makes d_error latch a bus-error flag and halt.

module ibex_tlul_fetch_fsm
  import ibex_tlul_core_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_en,
  input  logic [23:0] boot_base,
  input  logic        a_ready,
  input  logic        d_valid,
  input  logic        d_error,
  input  logic [31:0] d_data,
  output logic        a_valid,
  output logic [31:0] a_address,
  output logic        d_ready,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        bus_err,
  output logic        sleep
);

  fetch_state_e state_q;
  fetch_state_e state_d;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic         bus_err_q;
  logic         rsp_done_s;
  logic         rsp_err_s;
  logic         rsp_ok_s;

  assign rsp_done_s = (state_q == StRsp) && d_valid;

`ifdef IBEX_TLUL_BUS_ERR_ALERT_EN
  assign rsp_err_s = rsp_done_s && d_error;
`else
  logic unused_d_error_s;
  assign unused_d_error_s = d_error;
  assign rsp_err_s = 1'b0;
`endif

  assign rsp_ok_s = rsp_done_s && !rsp_err_s;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a request once raised is held until accepted
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (fetch_en) begin
          state_d = StReq;
        end else begin
          state_d = StIdle;
        end
      end
      StReq: begin
        if (a_ready) begin
          state_d = StRsp;
        end else begin
          state_d = StReq;
        end
      end
      StRsp: begin
        if (rsp_err_s) begin
          state_d = StHalt;
        end else if (rsp_ok_s) begin
          state_d = fetch_en ? StReq : StIdle;
        end else begin
          state_d = StRsp;
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  // Output decode of the current state
  always_comb begin
    a_valid = 1'b0;
    d_ready = 1'b0;
    sleep   = 1'b0;
    case (state_q)
      StIdle:  sleep   = 1'b1;
      StReq:   a_valid = 1'b1;
      StRsp:   d_ready = 1'b1;
      StHalt:  sleep   = 1'b1;
      default: sleep   = 1'b1;
    endcase
  end

  // PC, fetched word and sticky bus-error flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q      <= {boot_base, BootOffset};
      instr_q   <= 32'h0000_0000;
      bus_err_q <= 1'b0;
    end else begin
      if (rsp_ok_s) begin
        pc_q    <= next_word_addr(pc_q);
        instr_q <= d_data;
      end
      if (rsp_err_s) begin
        bus_err_q <= 1'b1;
      end
    end
  end

  assign a_address = pc_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign bus_err   = bus_err_q;

endmodule

// File: rtl/ibex_tlul_core.sv
// Pin-compatible Ibex CPU slot that only fetches sequential words over TL-UL.
// IBEX_TLUL_BUS_ERR_ALERT_EN enables the bus-error alert and halt.

module ibex_tlul_core
  import ibex_tlul_core_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         test_en_i,
  input  prim_ram_1p_pkg::ram_1p_cfg_t ram_cfg_i,
  input  logic [31:0]                  hart_id_i,
  input  logic [31:0]                  boot_addr_i,
  output tlul_pkg::tl_h2d_t            tl_i_o,
  input  tlul_pkg::tl_d2h_t            tl_i_i,
  output tlul_pkg::tl_h2d_t            tl_d_o,
  input  tlul_pkg::tl_d2h_t            tl_d_i,
  input  logic                         irq_software_i,
  input  logic                         irq_timer_i,
  input  logic                         irq_external_i,
  input  logic                         irq_nm_i,
  input  logic                         debug_req_i,
  output ibex_pkg::crash_dump_t        crash_dump_o,
  input  prim_mubi_pkg::mubi4_t        fetch_enable_i,
  output logic                         alert_minor_o,
  output logic                         alert_major_internal_o,
  output logic                         alert_major_bus_o,
  output logic                         debug_fault_seen_o,
  output logic                         core_sleep_o,
  input  logic                         scan_rst_ni,
  input  prim_mubi_pkg::mubi4_t        scanmode_i
);

  logic        fetch_en_s;
  logic        a_valid_s;
  logic [31:0] a_address_s;
  logic        d_ready_s;
  logic [31:0] pc_s;
  logic [31:0] instr_s;
  logic        bus_err_s;
  logic        sleep_s;

  assign fetch_en_s = (fetch_enable_i == ibex_pkg::FetchEnableOn);

  ibex_tlul_fetch_fsm u_fetch_fsm (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .fetch_en  (fetch_en_s),
    .boot_base (boot_addr_i[31:8]),
    .a_ready   (tl_i_i.a_ready),
    .d_valid   (tl_i_i.d_valid),
    .d_error   (tl_i_i.d_error),
    .d_data    (tl_i_i.d_data),
    .a_valid   (a_valid_s),
    .a_address (a_address_s),
    .d_ready   (d_ready_s),
    .pc        (pc_s),
    .instr     (instr_s),
    .bus_err   (bus_err_s),
    .sleep     (sleep_s)
  );

  // Instruction port: word-sized Get requests from the fetcher
  always_comb begin
    tl_i_o           = '0;
    tl_i_o.a_valid   = a_valid_s;
    tl_i_o.a_opcode  = tlul_pkg::Get;
    tl_i_o.a_param   = 3'd0;
    tl_i_o.a_size    = 2'(FetchSize);
    tl_i_o.a_source  = 8'd0;
    tl_i_o.a_address = a_address_s;
    tl_i_o.a_mask    = 4'hF;
    tl_i_o.a_data    = 32'd0;
    tl_i_o.a_user    = tlul_pkg::TL_A_USER_DEFAULT;
    tl_i_o.d_ready   = d_ready_s;
  end

  // Data port parked: never requests, always sinks stray responses
  always_comb begin
    tl_d_o          = '0;
    tl_d_o.a_valid  = 1'b0;
    tl_d_o.a_opcode = tlul_pkg::PutFullData;
    tl_d_o.a_user   = tlul_pkg::TL_A_USER_DEFAULT;
    tl_d_o.d_ready  = 1'b1;
  end

  // Crash dump carries only the fetch PC
  always_comb begin
    crash_dump_o                = '0;
    crash_dump_o.current_pc     = pc_s;
    crash_dump_o.next_pc        = next_word_addr(pc_s);
    crash_dump_o.last_data_addr = 32'd0;
  end

  assign alert_minor_o          = 1'b0;
  assign alert_major_internal_o = 1'b0;
  assign alert_major_bus_o      = bus_err_s;
  assign debug_fault_seen_o     = 1'b0;
  assign core_sleep_o           = sleep_s;

  // The fetched word is kept for the decode stage that will replace this slot
  logic unused_inputs_s;
  assign unused_inputs_s = ^{test_en_i, ram_cfg_i, hart_id_i, boot_addr_i[7:0],
                             tl_i_i, tl_d_i, irq_software_i, irq_timer_i,
                             irq_external_i, irq_nm_i, debug_req_i, scan_rst_ni,
                             scanmode_i, instr_s};

endmodule

// File: tb/tb_ibex_tlul_core.sv
// Scoreboard bench for ibex_tlul_core: expected fetch addresses are queued
// when a scenario is set up and popped as the core issues requests.

module tb_ibex_tlul_core;
  import tlul_pkg::*;
  import prim_mubi_pkg::*;

  logic                         clk;
  logic                         rst;
  logic [31:0]                  boot_addr;
  mubi4_t                       fetch_en;
  tl_h2d_t                      tl_i_req;
  tl_d2h_t                      tl_i_rsp;
  tl_h2d_t                      tl_d_req;
  tl_d2h_t                      tl_d_rsp;
  ibex_pkg::crash_dump_t        crash;
  prim_ram_1p_pkg::ram_1p_cfg_t ram_cfg;
  logic alert_minor, alert_major_int, alert_major_bus, dbg_fault, core_sleep;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] exp_q[$];

  ibex_tlul_core dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .test_en_i              (1'b0),
    .ram_cfg_i              (ram_cfg),
    .hart_id_i              (32'd0),
    .boot_addr_i            (boot_addr),
    .tl_i_o                 (tl_i_req),
    .tl_i_i                 (tl_i_rsp),
    .tl_d_o                 (tl_d_req),
    .tl_d_i                 (tl_d_rsp),
    .irq_software_i         (1'b0),
    .irq_timer_i            (1'b0),
    .irq_external_i         (1'b0),
    .irq_nm_i               (1'b0),
    .debug_req_i            (1'b0),
    .crash_dump_o           (crash),
    .fetch_enable_i         (fetch_en),
    .alert_minor_o          (alert_minor),
    .alert_major_internal_o (alert_major_int),
    .alert_major_bus_o      (alert_major_bus),
    .debug_fault_seen_o     (dbg_fault),
    .core_sleep_o           (core_sleep),
    .scan_rst_ni            (1'b1),
    .scanmode_i             (MuBi4False)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reset for two cycles, checking the reset-state outputs, then release
  task automatic do_reset(input logic [31:0] boot);
    rst       = 1'b1;
    boot_addr = boot;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_i_a_valid", {31'd0, tl_i_req.a_valid}, 32'd0);
    check_eq("rst_d_a_valid", {31'd0, tl_d_req.a_valid}, 32'd0);
    check_eq("rst_i_d_ready", {31'd0, tl_i_req.d_ready}, 32'd0);
    check_eq("rst_sleep", {31'd0, core_sleep}, 32'd1);
    check_eq("rst_alerts", {29'd0, alert_minor, alert_major_int, alert_major_bus}, 32'd0);
    check_eq("rst_pc", crash.current_pc, {boot[31:8], 8'h80});
    rst = 1'b0;
  endtask

  // Accept one request, compare its address with the scoreboard, then respond
  task automatic fetch_one(input logic [31:0] data, input logic err);
    logic [31:0] exp_addr;
    tl_i_rsp.a_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (tl_i_req.a_valid) break;
      @(negedge clk);
    end
    check_eq("a_valid_seen", {31'd0, tl_i_req.a_valid}, 32'd1);
    exp_addr = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check_eq("a_address", tl_i_req.a_address, exp_addr);
    @(negedge clk);
    tl_i_rsp.a_ready = 1'b0;
    tl_i_rsp.d_valid = 1'b1;
    tl_i_rsp.d_data  = data;
    tl_i_rsp.d_error = err;
    check_eq("rsp_d_ready", {31'd0, tl_i_req.d_ready}, 32'd1);
    @(negedge clk);
    tl_i_rsp.d_valid = 1'b0;
    tl_i_rsp.d_error = 1'b0;
  endtask

  initial begin
    logic [31:0] addr;
    rst       = 1'b1;
    boot_addr = 32'd0;
    fetch_en  = MuBi4True;
    ram_cfg   = '0;
    tl_i_rsp  = '0;
    tl_i_rsp.d_opcode = AccessAckData;
    tl_d_rsp  = '0;

    // Boot at 0 with a_ready low: request must appear one cycle after reset and hold
    do_reset(32'd0);
    @(negedge clk);
    check_eq("first_req", {31'd0, tl_i_req.a_valid}, 32'd1);
    check_eq("a_opcode", {29'd0, tl_i_req.a_opcode}, {29'd0, Get});
    check_eq("a_size_mask", {26'd0, tl_i_req.a_size, tl_i_req.a_mask}, 32'h2F);
    check_eq("d_port_d_ready", {31'd0, tl_d_req.d_ready}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("hold_a_valid", {31'd0, tl_i_req.a_valid}, 32'd1);
      check_eq("hold_addr", tl_i_req.a_address, 32'h80);
    end
    for (int k = 0; k < 6; k++) exp_q.push_back(32'h80 + 32'(4 * k));
    for (int k = 0; k < 6; k++) begin
      fetch_one((k == 0) ? 32'd0 : $urandom, 1'b0);
      check_eq("pc_after_ack", crash.current_pc, 32'h80 + 32'(4 * (k + 1)));
      check_eq("next_pc", crash.next_pc, 32'h84 + 32'(4 * (k + 1)));
    end

    // Low byte of boot address ignored; reset abandons the pending request
    do_reset(32'h1000_00FF);
    exp_q.push_back(32'h1000_0080);
    fetch_one(32'h1234_5678, 1'b0);

    // Fetch disabled while requesting: request still completes, then idle
    fetch_en = MuBi4False;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("req_held_off", {tl_i_req.a_valid, tl_i_req.a_address[30:0]}, {1'b1, 31'h1000_0084});
    end
    exp_q.push_back(32'h1000_0084);
    fetch_one(32'hCAFE_F00D, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check_eq("idle_after_off", {30'd0, tl_i_req.a_valid, core_sleep}, 32'd1);
      @(negedge clk);
    end

    // PC wraps past the top of the address space
    fetch_en = MuBi4True;
    do_reset(32'hFFFF_FF00);
    addr = 32'hFFFF_FF80;
    for (int k = 0; k < 34; k++) begin
      exp_q.push_back(addr);
      addr = addr + 32'd4;
    end
    for (int k = 0; k < 34; k++) fetch_one($urandom, 1'b0);
    check_eq("wrap_pc", crash.current_pc, 32'h0000_0008);

    // Fetch never enabled: no requests, core sleeps, stray responses ignored
    fetch_en = MuBi4False;
    do_reset(32'd0);
    tl_i_rsp.a_ready = 1'b1;
    tl_i_rsp.d_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("off_idle", {30'd0, tl_i_req.a_valid, core_sleep}, 32'd1);
    end
    check_eq("off_pc", crash.current_pc, 32'h80);
    tl_i_rsp.a_ready = 1'b0;
    tl_i_rsp.d_valid = 1'b0;

    // Bus error response
    fetch_en = MuBi4True;
    do_reset(32'd0);
    exp_q.push_back(32'h80);
    fetch_one(32'h0BAD_0BAD, 1'b1);
`ifdef IBEX_TLUL_BUS_ERR_ALERT_EN
    check_eq("bus_alert", {31'd0, alert_major_bus}, 32'd1);
    check_eq("err_pc", crash.current_pc, 32'h80);
    tl_i_rsp.a_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("halt_idle", {30'd0, tl_i_req.a_valid, core_sleep}, 32'd1);
      check_eq("halt_alert", {31'd0, alert_major_bus}, 32'd1);
    end
    tl_i_rsp.a_ready = 1'b0;
`else
    check_eq("no_bus_alert", {31'd0, alert_major_bus}, 32'd0);
    check_eq("err_pc", crash.current_pc, 32'h84);
    exp_q.push_back(32'h84);
    fetch_one(32'h1111_2222, 1'b0);
    check_eq("no_bus_alert_2", {31'd0, alert_major_bus}, 32'd0);
`endif

    check_eq("sb_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ibex_tlul_core.md
# ibex_tlul_core

Minimal RV32 hart front-end with TL-UL host ports, used as the CPU slot of the SoC before the full Ibex pipeline is integrated. It fetches sequential 32-bit words over the instruction TL-UL port, starting at the boot vector. The data port is held idle. It drives the standard Ibex crash-dump, alert and sleep outputs, so it is pin-compatible with the full core wrapper.

## Interface
- Parameters: none. Types come from `tlul_pkg`, `ibex_pkg`, `prim_mubi_pkg` and `prim_ram_1p_pkg`.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk_i` in 1: the single clock; all state updates on its rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `test_en_i` in 1; `ram_cfg_i` in `ram_1p_cfg_t`; `scan_rst_ni` in 1; `scanmode_i` in mubi4: accepted, unused.
- `hart_id_i` in 32: unused.
- `boot_addr_i` in 32: boot base; bits [7:0] ignored.
- `irq_software_i`, `irq_timer_i`, `irq_external_i`, `irq_nm_i`, `debug_req_i` in 1 each: unused.
- `fetch_enable_i` in mubi4: fetching permitted only when it equals `FetchEnableOn`.
- `tl_i_o` out `tl_h2d_t`; `tl_i_i` in `tl_d2h_t`: instruction host port.
- `tl_d_o` out `tl_h2d_t`; `tl_d_i` in `tl_d2h_t`: data host port.
- `crash_dump_o` out `crash_dump_t`: PC snapshot.
- `debug_fault_seen_o` out 1: constant 0.
- `alert_minor_o`, `alert_major_internal_o`: out 1 each, constant 0.
- `alert_major_bus_o` out 1: sticky bus-error alert.
- `core_sleep_o` out 1: high in IDLE and HALT.

## Operation
- Registers:
  - `pc_q` (32): on reset loads `{boot_addr_i[31:8], 8'h80}`.
  - `state_q`: one of IDLE, REQ, RSP, HALT.
  - `instr_q` (32): last fetched word.
  - `bus_err_q`: sticky bus-error flag.
- State transitions:
  - IDLE → REQ when `fetch_enable_i == FetchEnableOn`; otherwise stay in IDLE.
  - REQ: `a_valid=1`, `a_address=pc_q`. Move to RSP when `a_ready` is sampled high. The address and valid stay stable until accepted.
  - RSP: `d_ready=1`. On `d_valid` with `d_error=0`: `instr_q<=d_data`, `pc_q<=pc_q+4` (wraps modulo 2^32), go to REQ if fetch is still enabled, else IDLE.
  - RSP with `d_error=1`: go to HALT (terminal until reset); `pc_q` does not advance.
- `d_valid` outside RSP is ignored. `d_opcode`, `d_source` and `d_size` are not checked.
- Instruction A-channel constants: `a_opcode=Get`, `a_param=0`, `a_size=2`, `a_source=0`, `a_mask=4'hF`, `a_data=0`, `a_user=TL_A_USER_DEFAULT`.
- Data port: `a_valid=0`, `d_ready=1`, all other fields 0 or default; its responses are ignored.
- Crash dump:
  - `current_pc=pc_q`
  - `next_pc=pc_q+4`
  - `last_data_addr=0`
  - any remaining fields 0.

## Timing
- During reset: both `a_valid` are 0, `tl_i_o.d_ready=0`, all alerts 0, `core_sleep_o=1`, state IDLE.
- First `a_valid` is driven 1 cycle after reset deasserts, provided fetch is enabled.
- One outstanding transaction at most. Minimum fetch cycle is 2 clocks (REQ, RSP). The next REQ starts the cycle after the response is accepted.
- If `a_ready` and `d_valid` are both held high: REQ and RSP alternate. Addresses go 0x80, 0x84, 0x88, … for `boot_addr_i=0`.
- Reset asserted mid-transaction: the transaction is abandoned, state returns to IDLE, and `pc_q` reloads.
- If `fetch_enable_i` deasserts in REQ, the request is completed (TL-UL forbids retracting `a_valid`).

## Configuration
- `IBEX_TLUL_BUS_ERR_ALERT_EN` defined: `d_error` in RSP sets `bus_err_q`, which drives `alert_major_bus_o` until reset, and the FSM enters HALT.
- Not defined: `d_error` is treated as a normal response, `alert_major_bus_o` is tied 0, and HALT is unreachable.

## Structure
- Shared package `ibex_tlul_core_pkg`:
  - state enum;
  - `BootOffset = 8'h80`;
  - `FetchSize = 2`.
- One sub-module: `ibex_tlul_fetch_fsm`, holding the PC, state and A/D handshake. The top level maps ports, holds the data port idle and builds the crash dump.

## Test plan
- Reset, `boot_addr_i=0`, fetch on, `a_ready=0` → `a_valid=1`, address 128, held stable for 5 cycles.
- Then `a_ready=1`, `d_valid=1` with `AccessAckData`, data 0 → next request at address 132; 4 more acks → 136…148.
- `boot_addr_i=32'h1000_00FF` → first address `0x1000_0080`.
- `pc_q=0xFFFF_FFFC` (via `boot_addr_i` high, then loop) → wraps to `0x0000_0000`.
- `fetch_enable_i=MuBi4False` → `a_valid` stays 0 and `core_sleep_o=1` indefinitely.
- Macro defined, response with `d_error=1` → `alert_major_bus_o=1` next cycle, no further `a_valid`; macro undefined → fetch continues to the next address.
